// File: rtl/stack_engine.sv
// stack_engine: data stack with TOS/NOS held in registers and deeper
// entries spilled to a single-port synchronous-read RAM. Commands arrive
// over a valid/ready port. A POP that must pull the third entry back out
// of RAM takes one extra REFILL cycle; every other op completes in one cycle.
module stack_engine #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid_i,
  output logic                         cmd_ready_o,
  input  logic [2:0]                   cmd_op_i,
  input  logic [WIDTH-1:0]             cmd_data_i,
  output logic [WIDTH-1:0]             tos_o,
  output logic [WIDTH-1:0]             nos_o,
  output logic [$clog2(DEPTH+3)-1:0]   depth_o,
  output logic                         empty_o,
  output logic                         full_o,
  output logic                         err_ovf_o,
  output logic                         err_unf_o,
  input  logic                         clr_err_i
);

  localparam int DW  = $clog2(DEPTH + 3);
  localparam int SPW = $clog2(DEPTH + 1);
  localparam int AW  = $clog2(DEPTH);

  localparam logic [DW-1:0] FULL_DEPTH = DW'(DEPTH + 2);
  localparam logic [DW-1:0] ONE        = DW'(1);
  localparam logic [DW-1:0] TWO        = DW'(2);
  localparam logic [DW-1:0] THREE      = DW'(3);

  localparam logic [2:0] OP_PUSH    = 3'd1;
  localparam logic [2:0] OP_POP     = 3'd2;
  localparam logic [2:0] OP_DUP     = 3'd3;
  localparam logic [2:0] OP_SWAP    = 3'd4;
  localparam logic [2:0] OP_REPLACE = 3'd5;

  typedef enum logic {IDLE, REFILL} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] tos_q, tos_d;
  logic [WIDTH-1:0] nos_q, nos_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic [SPW-1:0]   sp_q, sp_d;
  logic             errOvf_q, errOvf_d;
  logic             errUnf_q, errUnf_d;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] memRdata_q;
  logic [AW-1:0]    memAddr;
  logic             memWe;
  logic             memRe;

  logic             ovfSet;
  logic             unfSet;
  logic             isEmpty;
  logic             isFull;

  assign isEmpty = (depth_q == '0);
  assign isFull  = (depth_q == FULL_DEPTH);

  // Next-state decode: one command per IDLE cycle; REFILL just lands the RAM word in NOS.
  always_comb begin
    state_d  = IDLE;
    tos_d    = tos_q;
    nos_d    = nos_q;
    depth_d  = depth_q;
    sp_d     = sp_q;
    memWe    = 1'b0;
    memRe    = 1'b0;
    memAddr  = sp_q[AW-1:0];
    ovfSet   = 1'b0;
    unfSet   = 1'b0;

    if (state_q == REFILL) begin
      nos_d = memRdata_q;
    end else if (cmd_valid_i) begin
      case (cmd_op_i)
        OP_PUSH, OP_DUP: begin
          if (cmd_op_i == OP_DUP && isEmpty) begin
            unfSet = 1'b1;
          end else if (isFull) begin
            ovfSet = 1'b1;
          end else begin
            tos_d   = (cmd_op_i == OP_DUP) ? tos_q : cmd_data_i;
            nos_d   = tos_q;
            depth_d = depth_q + ONE;
            if (depth_q >= TWO) begin
              memWe = 1'b1;
              sp_d  = sp_q + SPW'(1);
            end
          end
        end
        OP_POP: begin
          if (isEmpty) begin
            unfSet = 1'b1;
          end else begin
            tos_d   = nos_q;
            depth_d = depth_q - ONE;
            if (depth_q >= THREE) begin
              memRe   = 1'b1;
              memAddr = AW'(sp_q - SPW'(1));
              sp_d    = sp_q - SPW'(1);
              state_d = REFILL;
            end else begin
              nos_d = '0;
            end
          end
        end
        OP_SWAP: begin
          if (depth_q < TWO) begin
            unfSet = 1'b1;
          end else begin
            tos_d = nos_q;
            nos_d = tos_q;
          end
        end
        OP_REPLACE: begin
          if (isEmpty) begin
            unfSet = 1'b1;
          end else begin
            tos_d = cmd_data_i;
          end
        end
        default: begin
        end
      endcase
    end

    errOvf_d = ovfSet | (errOvf_q & ~clr_err_i);
    errUnf_d = unfSet | (errUnf_q & ~clr_err_i);
  end

  // Spill RAM: write NOS on a deepening push, read the third entry on a refilling pop.
  always_ff @(posedge clk) begin
    if (memWe) begin
      mem[memAddr] <= nos_q;
    end
    if (memRe) begin
      memRdata_q <= mem[memAddr];
    end
  end

  // Architectural state registers; reset abandons any in-flight refill.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      tos_q    <= '0;
      nos_q    <= '0;
      depth_q  <= '0;
      sp_q     <= '0;
      errOvf_q <= 1'b0;
      errUnf_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      tos_q    <= tos_d;
      nos_q    <= nos_d;
      depth_q  <= depth_d;
      sp_q     <= sp_d;
      errOvf_q <= errOvf_d;
      errUnf_q <= errUnf_d;
    end
  end

  assign cmd_ready_o = (state_q == IDLE);
  assign tos_o       = tos_q;
  assign nos_o       = nos_q;
  assign depth_o     = depth_q;
  assign empty_o     = isEmpty;
  assign full_o      = isFull;
  assign err_ovf_o   = errOvf_q;
  assign err_unf_o   = errUnf_q;

endmodule

// File: tb/tb_stack_engine.sv
// tb_stack_engine: drives a DEPTH=4 and a DEPTH=256 stack engine through a
// directed vector table, hand-written refill/reset sequences and a long
// random command stream compared against a queue-based stack model.
module tb_stack_engine;

  localparam int W = 32;

  localparam logic [2:0] NOP  = 3'd0;
  localparam logic [2:0] PUSH = 3'd1;
  localparam logic [2:0] POP  = 3'd2;
  localparam logic [2:0] DUP  = 3'd3;
  localparam logic [2:0] SWAP = 3'd4;
  localparam logic [2:0] REPL = 3'd5;

  logic clk = 1'b0;
  logic rst;
  logic sel;
  logic cVld;
  logic [2:0] cOp;
  logic [W-1:0] cData;
  logic cClr;

  logic sVld, sClr, bVld, bClr;
  logic sReady, sEmpty, sFull, sOvf, sUnf;
  logic bReady, bEmpty, bFull, bOvf, bUnf;
  logic [W-1:0] sTos, sNos, bTos, bNos;
  logic [2:0] sDepth;
  logic [8:0] bDepth;

  logic vReady, vEmpty, vFull, vOvf, vUnf;
  logic [W-1:0] vTos, vNos;
  logic [8:0] vDepth;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign sVld = cVld & ~sel;
  assign sClr = cClr & ~sel;
  assign bVld = cVld & sel;
  assign bClr = cClr & sel;

  stack_engine #(.WIDTH(W), .DEPTH(4)) dutSmall (
    .clk(clk), .rst(rst), .cmd_valid_i(sVld), .cmd_ready_o(sReady),
    .cmd_op_i(cOp), .cmd_data_i(cData), .tos_o(sTos), .nos_o(sNos),
    .depth_o(sDepth), .empty_o(sEmpty), .full_o(sFull),
    .err_ovf_o(sOvf), .err_unf_o(sUnf), .clr_err_i(sClr)
  );

  stack_engine #(.WIDTH(W), .DEPTH(256)) dutBig (
    .clk(clk), .rst(rst), .cmd_valid_i(bVld), .cmd_ready_o(bReady),
    .cmd_op_i(cOp), .cmd_data_i(cData), .tos_o(bTos), .nos_o(bNos),
    .depth_o(bDepth), .empty_o(bEmpty), .full_o(bFull),
    .err_ovf_o(bOvf), .err_unf_o(bUnf), .clr_err_i(bClr)
  );

  // Present whichever engine is currently selected as a single view.
  always_comb begin
    vReady = sel ? bReady : sReady;
    vTos   = sel ? bTos   : sTos;
    vNos   = sel ? bNos   : sNos;
    vDepth = sel ? bDepth : {6'd0, sDepth};
    vEmpty = sel ? bEmpty : sEmpty;
    vFull  = sel ? bFull  : sFull;
    vOvf   = sel ? bOvf   : sOvf;
    vUnf   = sel ? bUnf   : sUnf;
  end

  typedef struct {
    logic         vld;
    logic [2:0]   op;
    logic [W-1:0] data;
    logic         clr;
    logic [W-1:0] eTos;
    logic [W-1:0] eNos;
    int           eDepth;
    logic         eOvf;
    logic         eUnf;
    logic         eReady;
  } vec_t;

  vec_t tbl[39];

  logic [W-1:0] mq[$];
  logic mOvf, mUnf;

  function automatic vec_t mk(input logic v, input logic [2:0] o, input logic [W-1:0] d,
                              input logic c, input logic [W-1:0] t, input logic [W-1:0] n,
                              input int dp, input logic ov, input logic un, input logic rd);
    vec_t r;
    r.vld = v; r.op = o; r.data = d; r.clr = c;
    r.eTos = t; r.eNos = n; r.eDepth = dp; r.eOvf = ov; r.eUnf = un; r.eReady = rd;
    return r;
  endfunction

  task automatic checkVal(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 30)
        $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [W-1:0] eTos, input logic [W-1:0] eNos,
                             input int eDepth, input logic eOvf, input logic eUnf, input logic eReady);
    int cap;
    cap = sel ? 258 : 6;
    checkVal({tag, " tos"},   vTos, eTos);
    checkVal({tag, " nos"},   vNos, eNos);
    checkVal({tag, " depth"}, W'(vDepth), W'(eDepth));
    checkVal({tag, " empty"}, W'(vEmpty), W'(eDepth == 0));
    checkVal({tag, " full"},  W'(vFull), W'(eDepth == cap));
    checkVal({tag, " ovf"},   W'(vOvf), W'(eOvf));
    checkVal({tag, " unf"},   W'(vUnf), W'(eUnf));
    checkVal({tag, " ready"}, W'(vReady), W'(eReady));
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] o, input logic [W-1:0] d, input logic c);
    @(negedge clk);
    cVld = v; cOp = o; cData = d; cClr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1; cVld = 1'b0; cClr = 1'b0; cOp = NOP; cData = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Random stream against a queue model; top of stack is the queue's last element.
  task automatic runRandom(input logic which, input int nOps);
    int cap, pre, r;
    logic v, c, refill, ovfSet, unfSet;
    logic [2:0] o;
    logic [W-1:0] d, tmp, eT, eN;
    bit pushPhase;
    sel = which;
    cap = which ? 258 : 6;
    doReset();
    mq.delete();
    mOvf = 1'b0; mUnf = 1'b0;
    for (int i = 0; i < nOps; i++) begin
      pushPhase = ((i / 1000) % 2) == 0;
      r = $urandom_range(0, 99);
      if (r < 45)      o = pushPhase ? PUSH : POP;
      else if (r < 55) o = DUP;
      else if (r < 70) o = pushPhase ? POP : PUSH;
      else if (r < 82) o = SWAP;
      else if (r < 92) o = REPL;
      else if (r < 96) o = NOP;
      else             o = 3'($urandom_range(6, 7));
      v = ($urandom_range(0, 9) != 0);
      c = ($urandom_range(0, 15) == 0);
      d = $urandom;
      pre = mq.size();
      ovfSet = 1'b0; unfSet = 1'b0; refill = 1'b0;
      if (v) begin
        case (o)
          PUSH: if (pre == cap) ovfSet = 1'b1; else mq.push_back(d);
          DUP: begin
            if (pre == 0) unfSet = 1'b1;
            else if (pre == cap) ovfSet = 1'b1;
            else mq.push_back(mq[pre-1]);
          end
          REPL: if (pre == 0) unfSet = 1'b1; else mq[pre-1] = d;
          SWAP: begin
            if (pre < 2) unfSet = 1'b1;
            else begin
              tmp = mq[pre-1]; mq[pre-1] = mq[pre-2]; mq[pre-2] = tmp;
            end
          end
          POP: begin
            if (pre == 0) unfSet = 1'b1;
            else begin
              tmp = mq.pop_back();
              refill = (pre >= 3);
            end
          end
          default: ;
        endcase
      end
      mOvf = ovfSet | (mOvf & ~c);
      mUnf = unfSet | (mUnf & ~c);
      applyStimulus(v, o, d, c);
      if (refill) begin
        checkVal("rnd refill ready", W'(vReady), W'(0));
        cOp = 3'($urandom_range(0, 7));
        cData = $urandom;
        cClr = 1'b0;
        @(posedge clk);
        #1;
      end
      eT = (mq.size() >= 1) ? mq[mq.size()-1] : '0;
      eN = (mq.size() >= 2) ? mq[mq.size()-2] : '0;
      checkOutput(which ? "rnd256" : "rnd4", eT, eN, mq.size(), mOvf, mUnf, 1'b1);
    end
    @(negedge clk);
    cVld = 1'b0; cClr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; cVld = 1'b0; cOp = NOP; cData = '0; cClr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset small", '0, '0, 0, 1'b0, 1'b0, 1'b1);
    sel = 1'b1;
    #1;
    checkOutput("reset big", '0, '0, 0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    sel = 1'b0;

    tbl[0]  = mk(1, PUSH, 'h11, 0, 'h11, 'h00, 1, 0, 0, 1);
    tbl[1]  = mk(1, PUSH, 'h22, 0, 'h22, 'h11, 2, 0, 0, 1);
    tbl[2]  = mk(1, PUSH, 'h33, 0, 'h33, 'h22, 3, 0, 0, 1);
    tbl[3]  = mk(1, PUSH, 'h44, 0, 'h44, 'h33, 4, 0, 0, 1);
    tbl[4]  = mk(1, POP,  'h00, 0, 'h33, 'h33, 3, 0, 0, 0);
    tbl[5]  = mk(0, NOP,  'h00, 0, 'h33, 'h22, 3, 0, 0, 1);
    tbl[6]  = mk(1, PUSH, 'h55, 0, 'h55, 'h33, 4, 0, 0, 1);
    tbl[7]  = mk(1, PUSH, 'h66, 0, 'h66, 'h55, 5, 0, 0, 1);
    tbl[8]  = mk(1, PUSH, 'h77, 0, 'h77, 'h66, 6, 0, 0, 1);
    tbl[9]  = mk(1, PUSH, 'h88, 0, 'h77, 'h66, 6, 1, 0, 1);
    tbl[10] = mk(1, DUP,  'h00, 0, 'h77, 'h66, 6, 1, 0, 1);
    tbl[11] = mk(0, NOP,  'h00, 1, 'h77, 'h66, 6, 0, 0, 1);
    tbl[12] = mk(1, REPL, 'h99, 0, 'h99, 'h66, 6, 0, 0, 1);
    tbl[13] = mk(1, SWAP, 'h00, 0, 'h66, 'h99, 6, 0, 0, 1);
    tbl[14] = mk(1, 3'd6, 'hdead, 0, 'h66, 'h99, 6, 0, 0, 1);
    tbl[15] = mk(1, POP,  'h00, 0, 'h99, 'h99, 5, 0, 0, 0);
    tbl[16] = mk(0, NOP,  'h00, 0, 'h99, 'h55, 5, 0, 0, 1);
    tbl[17] = mk(1, POP,  'h00, 0, 'h55, 'h55, 4, 0, 0, 0);
    tbl[18] = mk(0, NOP,  'h00, 0, 'h55, 'h33, 4, 0, 0, 1);
    tbl[19] = mk(1, POP,  'h00, 0, 'h33, 'h33, 3, 0, 0, 0);
    tbl[20] = mk(0, NOP,  'h00, 0, 'h33, 'h22, 3, 0, 0, 1);
    tbl[21] = mk(1, POP,  'h00, 0, 'h22, 'h22, 2, 0, 0, 0);
    tbl[22] = mk(0, NOP,  'h00, 0, 'h22, 'h11, 2, 0, 0, 1);
    tbl[23] = mk(1, POP,  'h00, 0, 'h11, 'h00, 1, 0, 0, 1);
    tbl[24] = mk(1, SWAP, 'h00, 0, 'h11, 'h00, 1, 0, 1, 1);
    tbl[25] = mk(0, NOP,  'h00, 1, 'h11, 'h00, 1, 0, 0, 1);
    tbl[26] = mk(1, POP,  'h00, 0, 'h00, 'h00, 0, 0, 0, 1);
    tbl[27] = mk(1, POP,  'h00, 0, 'h00, 'h00, 0, 0, 1, 1);
    tbl[28] = mk(1, POP,  'h00, 1, 'h00, 'h00, 0, 0, 1, 1);
    tbl[29] = mk(0, NOP,  'h00, 1, 'h00, 'h00, 0, 0, 0, 1);
    tbl[30] = mk(1, DUP,  'h00, 0, 'h00, 'h00, 0, 0, 1, 1);
    tbl[31] = mk(1, REPL, 'h05, 0, 'h00, 'h00, 0, 0, 1, 1);
    tbl[32] = mk(0, NOP,  'h00, 1, 'h00, 'h00, 0, 0, 0, 1);
    tbl[33] = mk(1, PUSH, 'h0A, 0, 'h0A, 'h00, 1, 0, 0, 1);
    tbl[34] = mk(1, PUSH, 'h0B, 0, 'h0B, 'h0A, 2, 0, 0, 1);
    tbl[35] = mk(1, SWAP, 'h00, 0, 'h0A, 'h0B, 2, 0, 0, 1);
    tbl[36] = mk(1, DUP,  'h00, 0, 'h0A, 'h0A, 3, 0, 0, 1);
    tbl[37] = mk(1, 3'd7, 'h1234, 0, 'h0A, 'h0A, 3, 0, 0, 1);
    tbl[38] = mk(1, NOP,  'h5678, 0, 'h0A, 'h0A, 3, 0, 0, 1);

    for (int i = 0; i < 39; i++) begin
      applyStimulus(tbl[i].vld, tbl[i].op, tbl[i].data, tbl[i].clr);
      checkOutput($sformatf("vec%0d", i), tbl[i].eTos, tbl[i].eNos, tbl[i].eDepth,
                  tbl[i].eOvf, tbl[i].eUnf, tbl[i].eReady);
    end

    // cmd_valid held high through REFILL: the queued PUSH lands right after.
    doReset();
    applyStimulus(1, PUSH, 'h10, 0);
    applyStimulus(1, PUSH, 'h20, 0);
    applyStimulus(1, PUSH, 'h30, 0);
    applyStimulus(1, POP, 'h00, 0);
    checkOutput("hold accept", 'h20, 'h20, 2, 0, 0, 0);
    cOp = PUSH; cData = 'h77;
    @(posedge clk);
    #1;
    checkOutput("hold refill", 'h20, 'h10, 2, 0, 0, 1);
    @(posedge clk);
    #1;
    checkOutput("hold push", 'h77, 'h20, 3, 0, 0, 1);

    // Reset in the middle of a REFILL abandons the pending RAM read.
    doReset();
    for (int i = 1; i <= 5; i++) applyStimulus(1, PUSH, W'(i), 0);
    applyStimulus(1, POP, 'h00, 0);
    checkOutput("rstmid accept", 'h4, 'h4, 4, 0, 0, 0);
    rst = 1'b1;
    #2;
    checkOutput("rstmid async", '0, '0, 0, 0, 0, 1);
    @(negedge clk);
    rst = 1'b0; cVld = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rstmid after", '0, '0, 0, 0, 0, 1);
    applyStimulus(1, PUSH, 'h5A, 0);
    checkOutput("rstmid push", 'h5A, '0, 1, 0, 0, 1);

    runRandom(1'b0, 10000);
    runRandom(1'b1, 10000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
